// File: rtl/ycbcr_src_arbiter_pkg.sv
// Shared types for the two-source RGB front end of the YCbCr converter:
// FSM state encoding and the forwarded pixel group.
package ycbcr_pkg;

  localparam int VID_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    PASS = 2'd2
  } state_e;

  typedef struct packed {
    logic             vsync;
    logic             href;
    logic             clken;
    logic [VID_W-1:0] r;
    logic [VID_W-1:0] g;
    logic [VID_W-1:0] b;
  } pix_t;

endpackage

// File: rtl/ycbcr_src_arbiter_vsync_edge_det.sv
// Registered rising-edge detector for one source's vsync.
// The pulse is combinational from the live input and the previous-cycle flop.
module vsync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  output logic rise_o
);

  logic vsync_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values in the same time step.
  always_ff @(posedge clk) begin
    if (!rst_n) vsync_q <= 1'b0;
    else        vsync_q <= vsync_i;
  end

  assign rise_o = vsync_i & ~vsync_q;

endmodule

// File: rtl/ycbcr_src_arbiter.sv
// Frame-granular arbiter sharing one RGB->YCbCr converter between two sources.
// Ownership changes only on vsync rising edges, so no frame is ever spliced.
module ycbcr_src_arbiter
  import ycbcr_pkg::*;
#(
  parameter int FRAMES_PER_GRANT = 1,
  parameter int ARM_TIMEOUT      = 2000000,
  parameter int TO_W             = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       src_en,
  input  logic             s0_frame_vsync,
  input  logic             s0_frame_href,
  input  logic             s0_frame_clken,
  input  logic [VID_W-1:0] s0_img_red,
  input  logic [VID_W-1:0] s0_img_green,
  input  logic [VID_W-1:0] s0_img_blue,
  input  logic             s1_frame_vsync,
  input  logic             s1_frame_href,
  input  logic             s1_frame_clken,
  input  logic [VID_W-1:0] s1_img_red,
  input  logic [VID_W-1:0] s1_img_green,
  input  logic [VID_W-1:0] s1_img_blue,
  output logic             per_frame_vsync,
  output logic             per_frame_href,
  output logic             per_frame_clken,
  output logic [VID_W-1:0] per_img_red,
  output logic [VID_W-1:0] per_img_green,
  output logic [VID_W-1:0] per_img_blue,
  output logic             grant_id,
  output logic             grant_valid,
  output logic             frame_done,
  output logic             timeout_err
);

  localparam logic [7:0]      FPG     = 8'(FRAMES_PER_GRANT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ARM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            cand_q, cand_d;
  logic            last_q, last_d;
  logic [7:0]      fcnt_q, fcnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            terr_q, terr_d;
  logic            gv_q, gv_d;
  logic            fd_q, fd_d;
  pix_t            out_q, out_d;

  pix_t pix0, pix1, pix_g;
  logic rise0, rise1, rise_g, en_g, en_o;

  vsync_edge_det u_edge0 (.clk(clk), .rst_n(rst_n), .vsync_i(s0_frame_vsync), .rise_o(rise0));
  vsync_edge_det u_edge1 (.clk(clk), .rst_n(rst_n), .vsync_i(s1_frame_vsync), .rise_o(rise1));

  assign pix0   = '{s0_frame_vsync, s0_frame_href, s0_frame_clken, s0_img_red, s0_img_green, s0_img_blue};
  assign pix1   = '{s1_frame_vsync, s1_frame_href, s1_frame_clken, s1_img_red, s1_img_green, s1_img_blue};
  assign pix_g  = cand_q ? pix1 : pix0;
  assign rise_g = cand_q ? rise1 : rise0;
  assign en_g   = src_en[cand_q];
  assign en_o   = src_en[~cand_q];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= 1'b0;
      last_q  <= 1'b1;
      fcnt_q  <= '0;
      to_q    <= '0;
      terr_q  <= 1'b0;
      gv_q    <= 1'b0;
      fd_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      last_q  <= last_d;
      fcnt_q  <= fcnt_d;
      to_q    <= to_d;
      terr_q  <= terr_d;
      gv_q    <= gv_d;
      fd_q    <= fd_d;
      out_q   <= out_d;
    end
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    last_d  = last_q;
    fcnt_d  = fcnt_q;
    terr_d  = terr_q;
    to_d    = '0;
    case (state_q)
      IDLE: begin
        if (src_en != 2'b00) begin
          cand_d  = src_en[~last_q] ? ~last_q : last_q;
          state_d = ARM;
        end
      end
      ARM: begin
        if (!en_g) begin
          state_d = IDLE;
        end else if (rise_g) begin
          state_d = PASS;
          fcnt_d  = '0;
        end else if (to_q >= TO_LAST) begin
          terr_d  = 1'b1;
          last_d  = cand_q;
          state_d = IDLE;
        end else begin
          to_d = (&to_q) ? to_q : to_q + 1'b1;
        end
      end
      PASS: begin
        if (rise_g) begin
          // A disabled owner is released only once its frame is complete.
          if (!en_g) begin
            state_d = IDLE;
            last_d  = cand_q;
          end else if (fcnt_q + 8'd1 >= FPG) begin
            last_d = cand_q;
            fcnt_d = '0;
            if (en_o) begin
              state_d = ARM;
              cand_d  = ~cand_q;
            end
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: forward exactly the cycles that land in PASS
  always_comb begin
    gv_d  = (state_d == PASS);
    fd_d  = (state_q == PASS) && rise_g;
    out_d = '0;
    if (gv_d) out_d = pix_g;
  end

  assign per_frame_vsync = out_q.vsync;
  assign per_frame_href  = out_q.href;
  assign per_frame_clken = out_q.clken;
  assign per_img_red     = out_q.r;
  assign per_img_green   = out_q.g;
  assign per_img_blue    = out_q.b;
  assign grant_id        = cand_q;
  assign grant_valid     = gv_q;
  assign frame_done      = fd_q;
  assign timeout_err     = terr_q;

endmodule

// File: tb/tb_ycbcr_src_arbiter.sv
// Directed bench for ycbcr_src_arbiter: a vector table for single-frame
// handling, plus generated two-source sequences for switching, reset and timeout.
module tb_ycbcr_src_arbiter;
  import ycbcr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] src_en;
  logic       s0_frame_vsync, s0_frame_href, s0_frame_clken;
  logic [7:0] s0_img_red, s0_img_green, s0_img_blue;
  logic       s1_frame_vsync, s1_frame_href, s1_frame_clken;
  logic [7:0] s1_img_red, s1_img_green, s1_img_blue;

  logic       a_vs, a_hr, a_ck, a_gid, a_gv, a_fd, a_te;
  logic [7:0] a_r, a_g, a_b;
  logic       b_vs, b_hr, b_ck, b_gid, b_gv, b_fd, b_te;
  logic [7:0] b_r, b_g, b_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // One frame per grant
  ycbcr_src_arbiter #(.FRAMES_PER_GRANT(1), .ARM_TIMEOUT(100), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .src_en(src_en),
    .s0_frame_vsync(s0_frame_vsync), .s0_frame_href(s0_frame_href), .s0_frame_clken(s0_frame_clken),
    .s0_img_red(s0_img_red), .s0_img_green(s0_img_green), .s0_img_blue(s0_img_blue),
    .s1_frame_vsync(s1_frame_vsync), .s1_frame_href(s1_frame_href), .s1_frame_clken(s1_frame_clken),
    .s1_img_red(s1_img_red), .s1_img_green(s1_img_green), .s1_img_blue(s1_img_blue),
    .per_frame_vsync(a_vs), .per_frame_href(a_hr), .per_frame_clken(a_ck),
    .per_img_red(a_r), .per_img_green(a_g), .per_img_blue(a_b),
    .grant_id(a_gid), .grant_valid(a_gv), .frame_done(a_fd), .timeout_err(a_te)
  );

  // Three frames per grant, same stimulus
  ycbcr_src_arbiter #(.FRAMES_PER_GRANT(3), .ARM_TIMEOUT(100), .TO_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .src_en(src_en),
    .s0_frame_vsync(s0_frame_vsync), .s0_frame_href(s0_frame_href), .s0_frame_clken(s0_frame_clken),
    .s0_img_red(s0_img_red), .s0_img_green(s0_img_green), .s0_img_blue(s0_img_blue),
    .s1_frame_vsync(s1_frame_vsync), .s1_frame_href(s1_frame_href), .s1_frame_clken(s1_frame_clken),
    .s1_img_red(s1_img_red), .s1_img_green(s1_img_green), .s1_img_blue(s1_img_blue),
    .per_frame_vsync(b_vs), .per_frame_href(b_hr), .per_frame_clken(b_ck),
    .per_img_red(b_r), .per_img_green(b_g), .per_img_blue(b_b),
    .grant_id(b_gid), .grant_valid(b_gv), .frame_done(b_fd), .timeout_err(b_te)
  );

  logic [30:0] act_a, act_b;
  assign act_a = {a_vs, a_hr, a_ck, a_r, a_g, a_b, a_gid, a_gv, a_fd, a_te};
  assign act_b = {b_vs, b_hr, b_ck, b_r, b_g, b_b, b_gid, b_gv, b_fd, b_te};

  typedef struct packed {
    logic       rst_n;
    logic [1:0] en;
    logic [2:0] vhc;     // s0 {vsync, href, clken}
    logic [7:0] r;       // s0 red; green = red+85, blue = ~red
    logic [2:0] e_vhc;
    logic [7:0] e_r;
    logic [2:0] e_stat;  // {grant_id, grant_valid, frame_done}
  } vec_t;

  vec_t tbl [14];

  function automatic logic [30:0] mk(input pix_t p, input logic gid, input logic gv,
                                     input logic fd, input logic te);
    return {p, gid, gv, fd, te};
  endfunction

  // Frame generator: period 44, vsync on pos 0..1, 4 lines of 8 px from pos 4
  function automatic pix_t gen(input int s, input int t);
    int   pos, l, px;
    pix_t p;
    pos = (t + ((s != 0) ? 18 : 40)) % 44;
    p   = '0;
    if (pos < 2) begin
      p.vsync = 1'b1;
    end else if (pos >= 4) begin
      l  = (pos - 4) / 10;
      px = (pos - 4) % 10;
      if (px < 8) begin
        p.href  = 1'b1;
        p.clken = 1'b1;
        p.r     = 8'((l * 8 + px) * 8 + s * 4);
        p.g     = p.r + 8'd85;
        p.b     = ~p.r;
      end
    end
    return p;
  endfunction

  // Hand-derived schedule for the two-source run: s0 rises at 4,48,92,136,180;
  // s1 rises at 26,70,114,158,202; reset at 176.
  function automatic void exp_b(input bit three, input int t, output int fsrc,
                                output logic gid, output logic fd);
    fsrc = -1;
    gid  = 1'b0;
    fd   = 1'b0;
    if (t >= 176) begin
      if (t >= 180) fsrc = 0;
    end else if (!three) begin
      if (t >= 4 && t <= 47)        fsrc = 0;
      else if (t >= 70 && t <= 113) fsrc = 1;
      else if (t >= 136)            fsrc = 0;
      gid = (t >= 48 && t <= 113);
      fd  = (t == 48 || t == 114);
    end else begin
      if (t >= 4 && t <= 135) fsrc = 0;
      else if (t >= 158)      fsrc = 1;
      gid = (t >= 136);
      fd  = (t == 48 || t == 92 || t == 136);
    end
  endfunction

  task automatic check(input string name, input logic [30:0] act, input logic [30:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] en, input pix_t p0, input pix_t p1);
    rst_n  = r;
    src_en = en;
    {s0_frame_vsync, s0_frame_href, s0_frame_clken, s0_img_red, s0_img_green, s0_img_blue} = p0;
    {s1_frame_vsync, s1_frame_href, s1_frame_clken, s1_img_red, s1_img_green, s1_img_blue} = p1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_t        p0, p1, pe, s1_fill;
    logic [30:0] e;
    int          fsrc_a, fsrc_b;
    logic        gid_a, gid_b, fd_a, fd_b;

    s1_fill = '{vsync: 1'b0, href: 1'b1, clken: 1'b1, r: 8'hEE, g: 8'hEF, b: 8'hF0};
    drive(1'b0, 2'b00, '0, '0);

    // ---- Table: single source 0, one frame boundary, then src_en drop mid-frame
    tbl[0]  = '{1'b0, 2'b00, 3'b000, 8'h00, 3'b000, 8'h00, 3'b000};
    tbl[1]  = '{1'b1, 2'b00, 3'b000, 8'h00, 3'b000, 8'h00, 3'b000};
    tbl[2]  = '{1'b1, 2'b01, 3'b000, 8'h00, 3'b000, 8'h00, 3'b000};
    tbl[3]  = '{1'b1, 2'b01, 3'b011, 8'h11, 3'b000, 8'h00, 3'b000};
    tbl[4]  = '{1'b1, 2'b01, 3'b100, 8'h22, 3'b100, 8'h22, 3'b010};
    tbl[5]  = '{1'b1, 2'b01, 3'b100, 8'h23, 3'b100, 8'h23, 3'b010};
    tbl[6]  = '{1'b1, 2'b01, 3'b011, 8'h30, 3'b011, 8'h30, 3'b010};
    tbl[7]  = '{1'b1, 2'b01, 3'b010, 8'h31, 3'b010, 8'h31, 3'b010};
    tbl[8]  = '{1'b1, 2'b01, 3'b100, 8'h40, 3'b100, 8'h40, 3'b011};
    tbl[9]  = '{1'b1, 2'b01, 3'b000, 8'h41, 3'b000, 8'h41, 3'b010};
    tbl[10] = '{1'b1, 2'b00, 3'b011, 8'h50, 3'b011, 8'h50, 3'b010};
    tbl[11] = '{1'b1, 2'b00, 3'b100, 8'h60, 3'b000, 8'h00, 3'b001};
    tbl[12] = '{1'b1, 2'b00, 3'b100, 8'h61, 3'b000, 8'h00, 3'b000};
    tbl[13] = '{1'b0, 2'b00, 3'b011, 8'h62, 3'b000, 8'h00, 3'b000};

    for (int i = 0; i < 14; i++) begin
      p0 = '{vsync: tbl[i].vhc[2], href: tbl[i].vhc[1], clken: tbl[i].vhc[0],
             r: tbl[i].r, g: tbl[i].r + 8'd85, b: ~tbl[i].r};
      drive(tbl[i].rst_n, tbl[i].en, p0, s1_fill);
      pe = '{vsync: tbl[i].e_vhc[2], href: tbl[i].e_vhc[1], clken: tbl[i].e_vhc[0],
             r: tbl[i].e_r,
             g: tbl[i].e_stat[1] ? tbl[i].e_r + 8'd85 : 8'h00,
             b: tbl[i].e_stat[1] ? ~tbl[i].e_r : 8'h00};
      e = mk(pe, tbl[i].e_stat[2], tbl[i].e_stat[1], tbl[i].e_stat[0], 1'b0);
      check($sformatf("tbl[%0d] fpg1", i), act_a, e);
      check($sformatf("tbl[%0d] fpg3", i), act_b, e);
    end

    // ---- Two phase-offset sources, both enabled; reset mid-line at t=176
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'b00, '0, '0);
      check($sformatf("rst%0d fpg1", i), act_a, '0);
      check($sformatf("rst%0d fpg3", i), act_b, '0);
    end
    for (int t = 0; t <= 210; t++) begin
      drive((t == 176) ? 1'b0 : 1'b1, 2'b11, gen(0, t), gen(1, t));
      exp_b(1'b0, t, fsrc_a, gid_a, fd_a);
      exp_b(1'b1, t, fsrc_b, gid_b, fd_b);
      pe = (fsrc_a < 0) ? '0 : gen(fsrc_a, t);
      check($sformatf("alt t=%0d fpg1", t), act_a, mk(pe, gid_a, fsrc_a >= 0, fd_a, 1'b0));
      pe = (fsrc_b < 0) ? '0 : gen(fsrc_b, t);
      check($sformatf("alt t=%0d fpg3", t), act_b, mk(pe, gid_b, fsrc_b >= 0, fd_b, 1'b0));
    end

    // ---- Source 1 alone with vsync stuck low: arm timeout and sticky flag
    drive(1'b0, 2'b00, '0, '0);
    for (int t = 0; t <= 150; t++) begin
      p1 = gen(1, t);
      p1.vsync = 1'b0;
      drive(1'b1, 2'b10, gen(0, t), p1);
      e = mk('0, 1'b1, 1'b0, 1'b0, t >= 100);
      check($sformatf("tmo t=%0d fpg1", t), act_a, e);
      check($sformatf("tmo t=%0d fpg3", t), act_b, e);
    end
    drive(1'b0, 2'b10, '0, '0);
    check("tmo clear fpg1", act_a, '0);
    check("tmo clear fpg3", act_b, '0);
    drive(1'b1, 2'b00, '0, '0);
    check("post clear fpg1", act_a, '0);
    check("post clear fpg3", act_b, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
